// File: rtl/barrier_pkg.sv
// Shared defaults, derived widths and the per-workgroup slot record for the barrier unit.
// Optional watchdog is compiled in with BARRIER_TIMEOUT_EN.
package barrier_pkg;

  localparam int NUM_WF_DEF         = 40;
  localparam int NUM_WG_DEF         = 16;
  localparam int MAX_WF_PER_WG_DEF  = 16;
  localparam int TIMEOUT_CYCLES_DEF = 4096;

  localparam int WF_ID_W_DEF = $clog2(NUM_WF_DEF);
  localparam int WG_ID_W_DEF = $clog2(NUM_WG_DEF);
  localparam int CNT_W_DEF   = $clog2(MAX_WF_PER_WG_DEF + 1);

  // Sized for the default configuration; widen here before raising NUM_WF or MAX_WF_PER_WG.
  typedef struct packed {
    logic [CNT_W_DEF-1:0]  expected;
    logic [CNT_W_DEF-1:0]  arrived;
    logic [NUM_WF_DEF-1:0] bitmap;
    logic [31:0]           pc;
  } wg_slot_t;

endpackage

// File: rtl/barrier_wg_slot.sv
// One workgroup barrier slot: expected/arrived counts, waiting bitmap, last pc, release detect.
// With BARRIER_TIMEOUT_EN a saturating watchdog counter raises a one-shot timeout request.
module barrier_wg_slot
  import barrier_pkg::*;
#(
`ifdef BARRIER_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
`endif
  parameter int NUM_WF        = NUM_WF_DEF,
  parameter int MAX_WF_PER_WG = MAX_WF_PER_WG_DEF,
  localparam int CNT_W        = $clog2(MAX_WF_PER_WG + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc,
  input  logic [CNT_W-1:0]  alloc_count,
  input  logic              arrive,
  input  logic [NUM_WF-1:0] arrive_bit,
  input  logic [31:0]       arrive_pc,
  input  logic              done,
  output logic [CNT_W-1:0]  expected,
  output logic [NUM_WF-1:0] bitmap,
  output logic              rel,
  output logic [NUM_WF-1:0] rel_bitmap,
  output logic [31:0]       rel_pc
`ifdef BARRIER_TIMEOUT_EN
  ,
  input  logic              timeout_ack,
  output logic              timeout_req
`endif
);

  wg_slot_t          st;
  logic [CNT_W-1:0]  arr_q;
  logic [31:0]       pc_q;
  logic [CNT_W-1:0]  exp_n;
  logic [CNT_W-1:0]  arr_inc;
  logic [NUM_WF-1:0] bm_inc;
  logic [31:0]       pc_n;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? v : v - CNT_W'(1);
  endfunction

  assign expected = CNT_W'(st.expected);
  assign arr_q    = CNT_W'(st.arrived);
  assign bitmap   = NUM_WF'(st.bitmap);
  assign pc_q     = st.pc;

  // A same-cycle done and arrival are both folded in before the release compare.
  always_comb begin
    exp_n   = done ? sat_dec(expected) : expected;
    arr_inc = arrive ? sat_inc(arr_q) : arr_q;
    bm_inc  = arrive ? (bitmap | arrive_bit) : bitmap;
    pc_n    = arrive ? arrive_pc : pc_q;
    rel        = (arrive || done) && !alloc && (arr_inc != '0) && (arr_inc >= exp_n);
    rel_bitmap = bm_inc;
    rel_pc     = pc_n;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= '0;
    end else if (alloc) begin
      st.expected <= CNT_W_DEF'(alloc_count);
      st.arrived  <= '0;
      st.bitmap   <= '0;
      st.pc       <= '0;
    end else if (rel) begin
      st.expected <= CNT_W_DEF'(exp_n);
      st.arrived  <= '0;
      st.bitmap   <= '0;
      st.pc       <= pc_n;
    end else begin
      st.expected <= CNT_W_DEF'(exp_n);
      st.arrived  <= CNT_W_DEF'(arr_inc);
      st.bitmap   <= NUM_WF_DEF'(bm_inc);
      st.pc       <= pc_n;
    end
  end

`ifdef BARRIER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0] to_cnt;
  logic            reported;

  // The reported flag holds off repeats until the barrier releases or the slot is reallocated.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt   <= '0;
      reported <= 1'b0;
    end else if (alloc || rel) begin
      to_cnt   <= '0;
      reported <= 1'b0;
    end else begin
      if (arr_q != '0 && to_cnt != TO_MAX) to_cnt <= to_cnt + TO_W'(1);
      if (timeout_ack) reported <= 1'b1;
    end
  end

  assign timeout_req = (to_cnt == TO_MAX) && !reported;
`endif

endmodule

// File: rtl/barrier_sync_unit.sv
// Workgroup barrier synchronisation: decodes arrivals/allocs/dones, flags protocol errors,
// and registers the per-wavefront hold vector and retire trace. Watchdog via BARRIER_TIMEOUT_EN.
module barrier_sync_unit
  import barrier_pkg::*;
#(
  parameter int NUM_WF         = NUM_WF_DEF,
  parameter int NUM_WG         = NUM_WG_DEF,
  parameter int MAX_WF_PER_WG  = MAX_WF_PER_WG_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  localparam int WF_ID_W       = $clog2(NUM_WF),
  localparam int WG_ID_W       = $clog2(NUM_WG),
  localparam int CNT_W         = $clog2(MAX_WF_PER_WG + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               f_decode_valid,
  input  logic               f_decode_barrier,
  input  logic [WF_ID_W-1:0] f_decode_wfid,
  input  logic [WG_ID_W-1:0] f_decode_wgid,
  input  logic [31:0]        f_decode_instr_pc,
  input  logic               wg_alloc_valid,
  input  logic [WG_ID_W-1:0] wg_alloc_wgid,
  input  logic [CNT_W-1:0]   wg_alloc_wf_count,
  input  logic               wf_done_valid,
  input  logic [WF_ID_W-1:0] wf_done_wfid,
  input  logic [WG_ID_W-1:0] wf_done_wgid,
  output logic [NUM_WF-1:0]  barrier_wait_arry,
  output logic               tracemon_barrier_retire_en,
  output logic [NUM_WF-1:0]  tracemon_barrier_retire_wf_bitmap,
  output logic [31:0]        tracemon_barrier_retire_pc,
  output logic               barrier_error
`ifdef BARRIER_TIMEOUT_EN
  ,
  output logic               barrier_timeout,
  output logic [WG_ID_W-1:0] barrier_timeout_wgid
`endif
);

  logic              arr_req, alloc_clash, arr_dup, arr_unalloc, done_waiting;
  logic              arr_ok, done_ok, err_d;
  logic [NUM_WF-1:0] arrive_bit;

  logic [NUM_WG-1:0] slot_alloc, slot_arrive, slot_done, slot_rel;
  logic [CNT_W-1:0]  slot_exp    [NUM_WG];
  logic [NUM_WF-1:0] slot_bm     [NUM_WG];
  logic [NUM_WF-1:0] slot_rel_bm [NUM_WG];
  logic [31:0]       slot_rel_pc [NUM_WG];

  logic              rel_en;
  logic [NUM_WF-1:0] rel_bm;
  logic [31:0]       rel_pc;
  logic [NUM_WF-1:0] wait_d;

  assign arr_req      = f_decode_valid & f_decode_barrier;
  assign arrive_bit   = NUM_WF'(1) << f_decode_wfid;
  assign alloc_clash  = arr_req && wg_alloc_valid && (wg_alloc_wgid == f_decode_wgid);
  assign arr_dup      = arr_req && barrier_wait_arry[f_decode_wfid];
  assign arr_unalloc  = arr_req && (slot_exp[f_decode_wgid] == '0);
  assign done_waiting = wf_done_valid && barrier_wait_arry[wf_done_wfid];
  assign arr_ok       = arr_req && !alloc_clash && !arr_dup && !arr_unalloc;
  assign done_ok      = wf_done_valid && !done_waiting;
  assign err_d        = alloc_clash || arr_dup || arr_unalloc || done_waiting;

`ifdef BARRIER_TIMEOUT_EN
  logic [NUM_WG-1:0]  to_req, to_ack;
  logic               to_any;
  logic [WG_ID_W-1:0] to_id;
`endif

  for (genvar g = 0; g < NUM_WG; g++) begin : g_slot
    assign slot_alloc[g]  = wg_alloc_valid && (wg_alloc_wgid == WG_ID_W'(g));
    assign slot_arrive[g] = arr_ok && (f_decode_wgid == WG_ID_W'(g));
    assign slot_done[g]   = done_ok && (wf_done_wgid == WG_ID_W'(g));

    barrier_wg_slot #(
`ifdef BARRIER_TIMEOUT_EN
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
`endif
      .NUM_WF         (NUM_WF),
      .MAX_WF_PER_WG  (MAX_WF_PER_WG)
    ) u_slot (
      .clk         (clk),
      .rst         (rst),
      .alloc       (slot_alloc[g]),
      .alloc_count (wg_alloc_wf_count),
      .arrive      (slot_arrive[g]),
      .arrive_bit  (arrive_bit),
      .arrive_pc   (f_decode_instr_pc),
      .done        (slot_done[g]),
      .expected    (slot_exp[g]),
      .bitmap      (slot_bm[g]),
      .rel         (slot_rel[g]),
      .rel_bitmap  (slot_rel_bm[g]),
      .rel_pc      (slot_rel_pc[g])
`ifdef BARRIER_TIMEOUT_EN
      ,
      .timeout_ack (to_ack[g]),
      .timeout_req (to_req[g])
`endif
    );
  end

  // Only the arrival slot and the done slot can release; the arrival release owns the trace port.
  always_comb begin
    wait_d = barrier_wait_arry;
    for (int g = 0; g < NUM_WG; g++) begin
      if (slot_alloc[g] || slot_rel[g]) wait_d = wait_d & ~slot_bm[g];
    end
    if (arr_ok && !slot_rel[f_decode_wgid]) wait_d = wait_d | arrive_bit;

    rel_en = 1'b0;
    rel_bm = '0;
    rel_pc = '0;
    if (arr_ok && slot_rel[f_decode_wgid]) begin
      rel_en = 1'b1;
      rel_bm = slot_rel_bm[f_decode_wgid];
      rel_pc = slot_rel_pc[f_decode_wgid];
    end else if (done_ok && slot_rel[wf_done_wgid]) begin
      rel_en = 1'b1;
      rel_bm = slot_rel_bm[wf_done_wgid];
      rel_pc = slot_rel_pc[wf_done_wgid];
    end
  end

  // Output register stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      barrier_wait_arry                 <= '0;
      tracemon_barrier_retire_en        <= 1'b0;
      tracemon_barrier_retire_wf_bitmap <= '0;
      tracemon_barrier_retire_pc        <= '0;
      barrier_error                     <= 1'b0;
    end else begin
      barrier_wait_arry                 <= wait_d;
      tracemon_barrier_retire_en        <= rel_en;
      tracemon_barrier_retire_wf_bitmap <= rel_bm;
      tracemon_barrier_retire_pc        <= rel_pc;
      barrier_error                     <= err_d;
    end
  end

`ifdef BARRIER_TIMEOUT_EN
  // Lowest expiring wgid is reported first; the others stay pending for later cycles.
  always_comb begin
    to_any = 1'b0;
    to_id  = '0;
    for (int g = NUM_WG - 1; g >= 0; g--) begin
      if (to_req[g]) begin
        to_any = 1'b1;
        to_id  = WG_ID_W'(g);
      end
    end
    to_ack = to_any ? (NUM_WG'(1) << to_id) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      barrier_timeout      <= 1'b0;
      barrier_timeout_wgid <= '0;
    end else begin
      barrier_timeout      <= to_any;
      barrier_timeout_wgid <= to_any ? to_id : '0;
    end
  end
`endif

endmodule

// File: tb/tb_barrier_sync_unit.sv
// Directed scoreboard bench for barrier_sync_unit; the watchdog section needs BARRIER_TIMEOUT_EN.
module tb_barrier_sync_unit;

  localparam int NWF = 40;
  localparam int NWG = 16;
  localparam int WFW = 6;
  localparam int WGW = 4;
  localparam int CW  = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic           f_decode_valid, f_decode_barrier;
  logic [WFW-1:0] f_decode_wfid;
  logic [WGW-1:0] f_decode_wgid;
  logic [31:0]    f_decode_instr_pc;
  logic           wg_alloc_valid;
  logic [WGW-1:0] wg_alloc_wgid;
  logic [CW-1:0]  wg_alloc_wf_count;
  logic           wf_done_valid;
  logic [WFW-1:0] wf_done_wfid;
  logic [WGW-1:0] wf_done_wgid;
  logic [NWF-1:0] barrier_wait_arry;
  logic           tracemon_barrier_retire_en;
  logic [NWF-1:0] tracemon_barrier_retire_wf_bitmap;
  logic [31:0]    tracemon_barrier_retire_pc;
  logic           barrier_error;
`ifdef BARRIER_TIMEOUT_EN
  logic           barrier_timeout;
  logic [WGW-1:0] barrier_timeout_wgid;
`endif

  always #5 clk = ~clk;

  barrier_sync_unit #(
    .NUM_WF(NWF), .NUM_WG(NWG), .MAX_WF_PER_WG(16), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk                               (clk),
    .rst                               (rst),
    .f_decode_valid                    (f_decode_valid),
    .f_decode_barrier                  (f_decode_barrier),
    .f_decode_wfid                     (f_decode_wfid),
    .f_decode_wgid                     (f_decode_wgid),
    .f_decode_instr_pc                 (f_decode_instr_pc),
    .wg_alloc_valid                    (wg_alloc_valid),
    .wg_alloc_wgid                     (wg_alloc_wgid),
    .wg_alloc_wf_count                 (wg_alloc_wf_count),
    .wf_done_valid                     (wf_done_valid),
    .wf_done_wfid                      (wf_done_wfid),
    .wf_done_wgid                      (wf_done_wgid),
    .barrier_wait_arry                 (barrier_wait_arry),
    .tracemon_barrier_retire_en        (tracemon_barrier_retire_en),
    .tracemon_barrier_retire_wf_bitmap (tracemon_barrier_retire_wf_bitmap),
    .tracemon_barrier_retire_pc        (tracemon_barrier_retire_pc),
    .barrier_error                     (barrier_error)
`ifdef BARRIER_TIMEOUT_EN
    ,
    .barrier_timeout                   (barrier_timeout),
    .barrier_timeout_wgid              (barrier_timeout_wgid)
`endif
  );

  typedef struct {
    logic [NWF-1:0] w;
    logic           r;
    logic [NWF-1:0] bm;
    logic [31:0]    pc;
    logic           er;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic idle();
    f_decode_valid = 1'b0; f_decode_barrier = 1'b0; f_decode_wfid = '0; f_decode_wgid = '0;
    f_decode_instr_pc = '0;
    wg_alloc_valid = 1'b0; wg_alloc_wgid = '0; wg_alloc_wf_count = '0;
    wf_done_valid = 1'b0; wf_done_wfid = '0; wf_done_wgid = '0;
  endtask

  task automatic arrive(input int wf, input int wg, input logic [31:0] pc);
    f_decode_valid = 1'b1; f_decode_barrier = 1'b1;
    f_decode_wfid = WFW'(wf); f_decode_wgid = WGW'(wg); f_decode_instr_pc = pc;
  endtask

  task automatic alloc(input int wg, input int cnt);
    wg_alloc_valid = 1'b1; wg_alloc_wgid = WGW'(wg); wg_alloc_wf_count = CW'(cnt);
  endtask

  task automatic done(input int wf, input int wg);
    wf_done_valid = 1'b1; wf_done_wfid = WFW'(wf); wf_done_wgid = WGW'(wg);
  endtask

  task automatic push_exp(input string tag, input logic [NWF-1:0] w, input logic r,
                          input logic [NWF-1:0] bm, input logic [31:0] pc, input logic er);
    exp_t e;
    e.w = w; e.r = r; e.bm = bm; e.pc = pc; e.er = er;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_out();
    exp_t  e;
    string t;
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (barrier_wait_arry === e.w) else begin
      errors++; $error("FAIL %s wait_arry observed=%h expected=%h", t, barrier_wait_arry, e.w);
    end
    checks++;
    assert (tracemon_barrier_retire_en === e.r) else begin
      errors++; $error("FAIL %s retire_en observed=%b expected=%b", t, tracemon_barrier_retire_en, e.r);
    end
    checks++;
    assert (tracemon_barrier_retire_wf_bitmap === e.bm) else begin
      errors++; $error("FAIL %s retire_bitmap observed=%h expected=%h", t, tracemon_barrier_retire_wf_bitmap, e.bm);
    end
    checks++;
    assert (tracemon_barrier_retire_pc === e.pc) else begin
      errors++; $error("FAIL %s retire_pc observed=%h expected=%h", t, tracemon_barrier_retire_pc, e.pc);
    end
    checks++;
    assert (barrier_error === e.er) else begin
      errors++; $error("FAIL %s barrier_error observed=%b expected=%b", t, barrier_error, e.er);
    end
  endtask

  // Inputs set by the caller are sampled at the next posedge; outputs are checked at the negedge after.
  task automatic cyc(input string tag, input logic [NWF-1:0] w, input logic r,
                     input logic [NWF-1:0] bm, input logic [31:0] pc, input logic er);
    push_exp(tag, w, r, bm, pc, er);
    @(posedge clk);
    @(negedge clk);
    check_out();
    idle();
  endtask

`ifdef BARRIER_TIMEOUT_EN
  int             to_pulses;
  int             to_first;
  logic [WGW-1:0] to_wgid;
`endif

  initial begin
    idle();
    rst = 1'b0;
    @(negedge clk);
    push_exp("reset_state", '0, 1'b0, '0, 32'h0, 1'b0);
    check_out();
    cyc("reset_hold", '0, 1'b0, '0, 32'h0, 1'b0);
    rst = 1'b1;

    // Three-wavefront barrier in wg 2
    alloc(2, 3);             cyc("a_alloc", '0, 1'b0, '0, 32'h0, 1'b0);
    arrive(4, 2, 32'h40);    cyc("a_wf4", 40'h10, 1'b0, '0, 32'h0, 1'b0);
    arrive(5, 2, 32'h80);    cyc("a_wf5", 40'h30, 1'b0, '0, 32'h0, 1'b0);
    arrive(6, 2, 32'h100);   cyc("a_release", '0, 1'b1, 40'h70, 32'h100, 1'b0);
    cyc("a_pulse_end", '0, 1'b0, '0, 32'h0, 1'b0);

    f_decode_valid = 1'b1; f_decode_barrier = 1'b0; f_decode_wfid = WFW'(20); f_decode_wgid = WGW'(2);
    f_decode_instr_pc = 32'h123;
    cyc("non_barrier_decode", '0, 1'b0, '0, 32'h0, 1'b0);

    // Single-wavefront workgroup releases immediately
    alloc(3, 1);             cyc("b_alloc", '0, 1'b0, '0, 32'h0, 1'b0);
    arrive(0, 3, 32'h200);   cyc("b_release", '0, 1'b1, 40'h1, 32'h200, 1'b0);
    cyc("b_idle", '0, 1'b0, '0, 32'h0, 1'b0);

    // Release triggered by a non-waiting wavefront terminating
    alloc(7, 3);             cyc("c_alloc", '0, 1'b0, '0, 32'h0, 1'b0);
    arrive(1, 7, 32'h300);   cyc("c_wf1", 40'h2, 1'b0, '0, 32'h0, 1'b0);
    arrive(2, 7, 32'h310);   cyc("c_wf2", 40'h6, 1'b0, '0, 32'h0, 1'b0);
    done(3, 7);              cyc("c_done_release", '0, 1'b1, 40'h6, 32'h310, 1'b0);

    // Duplicate arrival is rejected and does not count
    alloc(8, 3);             cyc("d_alloc", '0, 1'b0, '0, 32'h0, 1'b0);
    arrive(1, 8, 32'h400);   cyc("d_wf1", 40'h2, 1'b0, '0, 32'h0, 1'b0);
    arrive(1, 8, 32'h404);   cyc("d_dup", 40'h2, 1'b0, '0, 32'h0, 1'b1);
    arrive(9, 8, 32'h408);   cyc("d_wf9", 40'h202, 1'b0, '0, 32'h0, 1'b0);
    arrive(10, 8, 32'h40c);  cyc("d_release", '0, 1'b1, 40'h602, 32'h40c, 1'b0);

    // Done from a waiting wavefront is an error and ignored
    alloc(9, 2);             cyc("e_alloc", '0, 1'b0, '0, 32'h0, 1'b0);
    arrive(11, 9, 32'h500);  cyc("e_wf11", 40'h800, 1'b0, '0, 32'h0, 1'b0);
    done(11, 9);             cyc("e_done_waiting", 40'h800, 1'b0, '0, 32'h0, 1'b1);
    arrive(12, 9, 32'h508);  cyc("e_release", '0, 1'b1, 40'h1800, 32'h508, 1'b0);

    // Alloc beats a same-wgid arrival; a later alloc clears holds
    alloc(10, 2); arrive(13, 10, 32'h600);
    cyc("f_clash", '0, 1'b0, '0, 32'h0, 1'b1);
    arrive(13, 10, 32'h604); cyc("f_wf13", 40'h2000, 1'b0, '0, 32'h0, 1'b0);
    alloc(10, 2);            cyc("f_realloc_clear", '0, 1'b0, '0, 32'h0, 1'b0);

    // Same-cycle arrival and done in one wgid
    alloc(11, 3);            cyc("g_alloc", '0, 1'b0, '0, 32'h0, 1'b0);
    arrive(14, 11, 32'h700); cyc("g_wf14", 40'h4000, 1'b0, '0, 32'h0, 1'b0);
    arrive(15, 11, 32'h704); done(16, 11);
    cyc("g_combined_release", '0, 1'b1, 40'hc000, 32'h704, 1'b0);

    // Done with nobody waiting only lowers the expected count
    alloc(12, 2);            cyc("h_alloc", '0, 1'b0, '0, 32'h0, 1'b0);
    done(17, 12);            cyc("h_done_no_release", '0, 1'b0, '0, 32'h0, 1'b0);
    arrive(18, 12, 32'h800); cyc("h_release", '0, 1'b1, 40'h4_0000, 32'h800, 1'b0);

    // Highest wavefront id
    alloc(13, 2);            cyc("i_alloc", '0, 1'b0, '0, 32'h0, 1'b0);
    arrive(39, 13, 32'h880); cyc("i_wf39", 40'h80_0000_0000, 1'b0, '0, 32'h0, 1'b0);
    arrive(0, 13, 32'h884);  cyc("i_release", '0, 1'b1, 40'h80_0000_0001, 32'h884, 1'b0);

`ifdef BARRIER_TIMEOUT_EN
    alloc(5, 3);             cyc("t_alloc", '0, 1'b0, '0, 32'h0, 1'b0);
    arrive(19, 5, 32'h900);  cyc("t_wf19", 40'h8_0000, 1'b0, '0, 32'h0, 1'b0);
    to_pulses = 0;
    to_first  = -1;
    to_wgid   = '0;
    for (int i = 0; i < 20; i++) begin
      cyc("t_hold", 40'h8_0000, 1'b0, '0, 32'h0, 1'b0);
      if (barrier_timeout === 1'b1) begin
        if (to_first < 0) to_first = i;
        to_wgid = barrier_timeout_wgid;
        to_pulses++;
      end
    end
    checks++;
    assert (to_pulses == 1) else begin
      errors++; $error("FAIL timeout_pulses observed=%0d expected=1", to_pulses);
    end
    checks++;
    assert (to_first == 8) else begin
      errors++; $error("FAIL timeout_cycle observed=%0d expected=8", to_first);
    end
    checks++;
    assert (to_wgid === 4'd5) else begin
      errors++; $error("FAIL timeout_wgid observed=%0d expected=5", to_wgid);
    end
    alloc(5, 3);             cyc("t_realloc", '0, 1'b0, '0, 32'h0, 1'b0);
`endif

    // Asynchronous reset while a wavefront is held
    alloc(2, 3);             cyc("j_alloc", '0, 1'b0, '0, 32'h0, 1'b0);
    arrive(4, 2, 32'ha00);   cyc("j_wf4", 40'h10, 1'b0, '0, 32'h0, 1'b0);
    #1 rst = 1'b0;
    #1;
    push_exp("j_async_reset", '0, 1'b0, '0, 32'h0, 1'b0);
    check_out();
    @(negedge clk);
    push_exp("j_reset_held", '0, 1'b0, '0, 32'h0, 1'b0);
    check_out();
    rst = 1'b1;
    arrive(4, 2, 32'ha04);   cyc("j_unalloc_arrival", '0, 1'b0, '0, 32'h0, 1'b1);
    cyc("j_idle", '0, 1'b0, '0, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/barrier_sync_unit.md
BARRIER_SYNC_UNIT -- requirements
Module: barrier_sync_unit

Interface
REQ-001 SHALL have parameter NUM_WF, default 40, meaning wavefront slots per CU.
REQ-002 SHALL have parameter NUM_WG, default 16, meaning workgroup slots tracked.
REQ-003 SHALL have parameter MAX_WF_PER_WG, default 16, meaning maximum wavefronts in one workgroup.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 4096, meaning watchdog threshold, used only when BARRIER_TIMEOUT_EN is defined.
REQ-005 SHALL derive WF_ID_W = clog2(NUM_WF), WG_ID_W = clog2(NUM_WG) and CNT_W = clog2(MAX_WF_PER_WG+1) internally.
REQ-006 SHALL have ports, in order: clk in 1, single clock; rst in 1, asynchronous active-low reset.
REQ-007 SHALL have inputs f_decode_valid 1, f_decode_barrier 1, f_decode_wfid WF_ID_W, f_decode_wgid WG_ID_W, and f_decode_instr_pc 32, meaning decoded-instruction info.
REQ-008 SHALL have inputs wg_alloc_valid 1, wg_alloc_wgid WG_ID_W, and wg_alloc_wf_count CNT_W, meaning workgroup allocation.
REQ-009 SHALL have inputs wf_done_valid 1, wf_done_wfid WF_ID_W, and wf_done_wgid WG_ID_W, meaning wavefront termination.
REQ-010 SHALL have outputs barrier_wait_arry NUM_WF, meaning per-wavefront hold; tracemon_barrier_retire_en 1; tracemon_barrier_retire_wf_bitmap NUM_WF; tracemon_barrier_retire_pc 32; barrier_error 1.
REQ-011 SHALL have outputs barrier_timeout 1 and barrier_timeout_wgid WG_ID_W, present only with BARRIER_TIMEOUT_EN.

Function
REQ-012 SHALL hold per workgroup: expected count (CNT_W), arrived count (CNT_W), waiting bitmap (NUM_WF) and last-arrival pc (32).
REQ-013 SHALL treat arrival as f_decode_valid & f_decode_barrier.
REQ-014 SHALL make all outputs registered with 1-cycle latency from the causing input cycle.
REQ-015 SHALL, on an arrival where arrived+1 < expected, increment arrived, set the wfid bit in the slot bitmap and in barrier_wait_arry, and latch the pc.
REQ-016 SHALL, on an arrival where arrived+1 == expected, release: pulse tracemon_barrier_retire_en for 1 cycle with retire_wf_bitmap = slot bitmap | arriving wf bit and retire_pc = arriving pc.
REQ-017 SHALL, on release, clear the slot bitmap bits from barrier_wait_arry, zero arrived, and clear the bitmap; the final wf's hold bit is never set.
REQ-018 SHALL, on wf_done for a non-waiting wf, decrement expected; if the new expected equals arrived and arrived > 0, release using the latched pc.
REQ-019 SHALL, on arrival and wf_done for the same wgid in one cycle, apply both (expected-1, arrived+1) before the release compare.
REQ-020 SHALL make wg_alloc_valid load expected, zero arrived and the bitmap, and clear that slot's bits in barrier_wait_arry.
REQ-021 SHALL, when wg_alloc_valid coincides with an arrival to the same wgid, let alloc win, drop the arrival, and pulse barrier_error.
REQ-022 SHALL pulse barrier_error and ignore the event for: an arrival from a wf already waiting; an arrival to a slot with expected == 0; or wf_done for a waiting wf.
REQ-023 SHALL perform at most one release per cycle, since only one arrival/done port exists.
REQ-024 SHALL saturate counters and never let them wrap.

Reset
REQ-025 SHALL, while rst is low, zero every slot field, barrier_wait_arry, all tracemon outputs, barrier_error and timeout outputs, asynchronously.
REQ-026 SHALL drop any barrier in progress when reset is asserted mid-barrier; the first cycle after deassertion accepts new events.

Configuration
REQ-027 SHALL, with BARRIER_TIMEOUT_EN defined, give each slot a saturating cycle counter that runs while arrived > 0 and clears on release or alloc.
REQ-028 SHALL, with BARRIER_TIMEOUT_EN defined and a counter reaching TIMEOUT_CYCLES, pulse barrier_timeout once with the wgid, lowest wgid first if several expire together, and report no repeat until that slot clears.
REQ-029 SHALL, without BARRIER_TIMEOUT_EN, have no counters and no timeout ports.

Structure
REQ-030 SHALL place the default parameters, the derived widths, and a wg_slot_t struct (expected, arrived, bitmap, pc) in shared package barrier_pkg.
REQ-031 SHALL implement per-workgroup state and timeout in sub-module barrier_wg_slot, instantiated NUM_WG times; the top level does decode, error detection and output muxing.

Verification
REQ-032 SHALL verify: alloc wg 2 count 3; wf 4, 5 arrive -> barrier_wait_arry bits 4,5 set; wf 6 arrives pc 0x100 -> retire_en 1 cycle, bitmap bits 4,5,6, pc 0x100, arry bits clear.
REQ-033 SHALL verify: alloc count 1; wf 0 arrives -> immediate release, bit 0 never set.
REQ-034 SHALL verify: alloc count 3; wf 1, 2 arrive; wf_done wf 3 -> release with bitmap bits 1,2 and last latched pc.
REQ-035 SHALL verify: wf 1 arrives twice -> barrier_error on the second arrival, arrived stays 1.
REQ-036 SHALL verify: with BARRIER_TIMEOUT_EN and TIMEOUT_CYCLES=8, wg 5 partially arrived for 8 cycles -> barrier_timeout with wgid 5, one pulse only.
REQ-037 SHALL verify: rst low with wf 4 waiting -> all outputs 0 immediately; post-reset arrival to an unallocated slot -> barrier_error.
